// File: rtl/cskip_sub_seq_pkg.sv
// Shared types and constants for the block-serial borrow-skip subtractor.
package cskip_sub_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_BLK   = 4;

    function automatic int nblk(input int width, input int blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/cskip_sub_seq_if.sv
// Operand/result handshake bundle between producer, subtractor and consumer.
interface cskip_sub_seq_if
    import cskip_sub_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
);
    localparam int NBLK = nblk(WIDTH, BLK);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic [NBLK-1:0]  skip_mask;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, skip_mask
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, skip_mask
    );

endinterface

// File: rtl/cskip_sub_seq_blk.sv
// One combinational borrow-skip block: ripple a + ~b + ci, with a bypass of
// the carry when every bit position propagates.
module skip_sub_blk #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a_s,
    input  logic [BLK-1:0] b_s,
    input  logic           ci,
    output logic [BLK-1:0] d_s,
    output logic           co,
    output logic           p
);
    logic [BLK-1:0] nb;
    logic [BLK-1:0] prop;
    logic           c [BLK+1];

    assign nb   = ~b_s;
    assign prop = a_s ^ nb;
    assign c[0] = ci;

    genvar gi;
    generate
        for (gi = 0; gi < BLK; gi++) begin : g_bit
            assign d_s[gi]  = prop[gi] ^ c[gi];
            assign c[gi+1]  = (a_s[gi] & nb[gi]) | (c[gi] & prop[gi]);
        end
    endgenerate

    // a XNOR b over the whole block means the incoming carry passes straight out
    assign p  = &prop;
    assign co = p ? ci : c[BLK];

endmodule

// File: rtl/cskip_sub_seq.sv
// Block-serial subtractor: one skip block per clock, valid/ready on both sides.
module cskip_sub_seq
    import cskip_sub_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input logic              clk,
    input logic              rst,
    cskip_sub_seq_if.slave   bus
);
    localparam int NBLK  = nblk(WIDTH, BLK);
    localparam int CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int MSB   = WIDTH - 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic [NBLK-1:0]  mask_q, mask_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [BLK-1:0]   blk_a, blk_b, blk_d;
    logic             blk_co, blk_p;

    assign blk_a = a_q[cnt_q*BLK +: BLK];
    assign blk_b = b_q[cnt_q*BLK +: BLK];

    skip_sub_blk #(.BLK(BLK)) u_blk (
        .a_s (blk_a),
        .b_s (blk_b),
        .ci  (carry_q),
        .d_s (blk_d),
        .co  (blk_co),
        .p   (blk_p)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        mask_d   = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d[cnt_q*BLK +: BLK] = blk_d;
                mask_d[cnt_q]            = blk_p;
                carry_d                  = blk_co;
                if (cnt_q == CNT_W'(NBLK - 1)) begin
                    // top block's fresh sum bits supply the result sign
                    borrow_d = ~blk_co;
                    ovf_d    = (a_q[MSB] != b_q[MSB]) & (blk_d[BLK-1] != a_q[MSB]);
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            mask_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            mask_q      <= mask_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
    assign bus.skip_mask = mask_q;

endmodule

// File: tb/tb_cskip_sub_seq.sv
// Directed bench for cskip_sub_seq with hand-computed expected results.
module tb_cskip_sub_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cskip_sub_seq_if #(.WIDTH(8), .BLK(4)) bus ();

    cskip_sub_seq #(.WIDTH(8), .BLK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, step through the accept edge and both block cycles,
    // checking the latency and the result at the first out_valid cycle.
    task automatic start_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [7:0] ed, input logic eb, input logic eo,
                            input logic [1:0] em);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready_wait"}, 32'(bus.in_ready), 32'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = 8'hFF;
        bus.b        = 8'h00;
        chk({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_lat1_ready"}, 32'(bus.in_ready), 32'd0);
        tick();
        chk({tag, "_lat2_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, "_lat3_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        chk({tag, "_mask"}, 32'(bus.skip_mask), 32'(em));
        $display("op %s a=%02h b=%02h diff=%02h borrow=%0d ovf=%0d mask=%02b",
                 tag, av, bv, bus.diff, bus.borrow, bus.ovf, bus.skip_mask);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_borrow", 32'(bus.borrow), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_mask", 32'(bus.skip_mask), 32'd0);
        rst = 1'b0;
        tick();

        start_op("t35m12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 2'b00);
        tick();
        chk("t35m12_valid_one_cycle", 32'(bus.out_valid), 32'd0);
        chk("t35m12_ready_back", 32'(bus.in_ready), 32'd1);
        chk("t35m12_diff_kept", 32'(bus.diff), 32'h23);

        start_op("t00m01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 2'b10);
        tick();
        start_op("t80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 2'b00);
        tick();
        start_op("t5Am5A", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 2'b11);
        tick();

        // Backpressure: result must hold and new operands must be ignored.
        bus.out_ready = 1'b0;
        start_op("t10m20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 2'b01);
        bus.a        = 8'hFF;
        bus.b        = 8'h00;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_diff", 32'(bus.diff), 32'hF0);
            chk("bp_borrow", 32'(bus.borrow), 32'd1);
            chk("bp_mask", 32'(bus.skip_mask), 32'b01);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        start_op("t07m03", 8'h07, 8'h03, 8'h04, 1'b0, 1'b0, 2'b10);
        tick();

        // Reset while the first block is being processed.
        chk("abort_pre_ready", 32'(bus.in_ready), 32'd1);
        bus.a        = 8'h44;
        bus.b        = 8'h11;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_diff", 32'(bus.diff), 32'd0);
        chk("abort_mask", 32'(bus.skip_mask), 32'd0);
        chk("abort_borrow", 32'(bus.borrow), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_result", 32'(bus.out_valid), 32'd0);
        end
        $display("op abort a=44 b=11 out_valid=%0d diff=%02h", bus.out_valid, bus.diff);

        start_op("tC3m3C", 8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0, 2'b00);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cskip_sub_seq.md
Name: cskip_sub_seq

Overview:
- Multi-cycle unsigned/two's-complement subtractor: diff = a - b, computed one block per clock.
- Each block has a borrow-skip bypass, so it is the subtract-direction counterpart of the team's carry-skip adder.
- Sits between operand producers and consumers behind valid/ready handshakes on input and output.
- Block serialisation trades latency for a short per-cycle critical path.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of BLK.
- BLK, 4, bits processed per clock (one skip block).
- NBLK, WIDTH/BLK, derived block count; not overridable.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b) mod 2^WIDTH
- borrow  output  1  1 when a < b unsigned
- ovf  output  1  signed overflow
- skip_mask  output  NBLK  bit k = 1 when block k took the skip path

Behaviour:
- Reset:
  - rst sampled high forces state IDLE; block counter 0.
  - diff, borrow, ovf and skip_mask are cleared to 0; out_valid = 0; in_ready = 1 on the next cycle.
  - This applies in every state, including mid-operation; any in-flight operation is discarded.
- Arithmetic:
  - Computed as a + ~b + 1.
  - Carry into block 0 is 1.
  - borrow = ~carry out of the top block.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
- Per-block skip:
  - P = AND over the block of (a[i] XNOR b[i]).
  - Block carry out = P ? carry_in : ripple carry out.
  - Sum bits always come from the ripple path.
  - skip_mask[k] records P of block k.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: register a and b, set carry register = 1, counter = 0, go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle processes block k = counter: writes diff[k*BLK +: BLK], skip_mask[k], and the carry register.
  - Increments counter; after block NBLK-1, computes borrow and ovf and goes to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - diff, borrow, ovf and skip_mask are held stable while out_ready = 0.
  - On out_ready: go to IDLE.
- Latency and throughput:
  - Accept edge at cycle 0; out_valid is high from cycle NBLK+1 (cycle 3 for defaults).
  - Throughput is one operation per NBLK+2 cycles minimum.
- Input stability: a and b are captured only on the accept edge; later input changes have no effect.
- Ignored input: in_valid while not in IDLE is ignored; no queueing.
- Output registers: diff, borrow, ovf and skip_mask are registered and change only in RUN, at the RUN-to-DONE transition, or on reset. They are not cleared on return to IDLE; the last result stays visible with out_valid = 0.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package contents:
  - FSM state enum (IDLE/RUN/DONE).
  - Default WIDTH/BLK constants.
  - Block-count helper function.
- Sub-module skip_sub_blk (combinational, BLK wide):
  - Inputs: a slice, b slice, carry in.
  - Outputs: diff slice, carry out (after skip mux), propagate flag.
  - Instantiated once and time-multiplexed by the counter.
- Top level holds the FSM, counter, operand registers and result registers.

Test Plan:
- a=0x35, b=0x12, out_ready=1:
  - diff=0x23, borrow=0, ovf=0, skip_mask=2'b00.
  - out_valid exactly 3 cycles after accept, for 1 cycle; in_ready back high the following cycle.
- a=0x00, b=0x01: diff=0xFF, borrow=1, ovf=0, skip_mask=2'b10.
- a=0x80, b=0x01: diff=0x7F, borrow=0, ovf=1, skip_mask=2'b00.
- a=0x5A, b=0x5A: diff=0x00, borrow=0, ovf=0, skip_mask=2'b11 (full skip chain, carry in 1 passes through).
- Backpressure, a=0x10, b=0x20, out_ready held low 5 cycles after out_valid:
  - Outputs held at diff=0xF0, borrow=1; in_ready=0.
  - A new in_valid with a=0xFF is ignored.
  - After out_ready is raised, the next accept yields an independent result.
- Reset mid-operation: assert rst for 1 cycle while in RUN:
  - Next cycle out_valid=0, in_ready=1, diff=0x00, skip_mask=0.
  - No result is ever presented for the aborted operands.
